// File: rtl/rr_arb16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pkg : shared sizes, state encoding and reset pointer for rr_arb16 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arb_pkg;

  localparam int NREQ  = 16;
  localparam int IDX_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } state_e;

  localparam logic [IDX_W-1:0] PTR_RST = 4'hF;

endpackage
`default_nettype wire

// File: rtl/rr_arb16_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb16_if : request/release and grant signals of the arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rr_arb16_if;

  logic [arb_pkg::NREQ-1:0]  req;
  logic                      done;
  logic                      gnt_vld;
  logic [arb_pkg::IDX_W-1:0] gnt_idx;
  logic [arb_pkg::NREQ-1:0]  gnt_oh;
  logic                      tmo;

  modport master (
    output req,
    output done,
    input  gnt_vld,
    input  gnt_idx,
    input  gnt_oh,
    input  tmo
  );

  modport slave (
    input  req,
    input  done,
    output gnt_vld,
    output gnt_idx,
    output gnt_oh,
    output tmo
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb16_dec4to16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dec4to16 : 4-bit index to 16-bit one-hot decoder                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dec4to16 (
  input  logic [3:0]  idx,
  output logic [15:0] oh
);

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign oh[i] = (idx == 4'(i));
  end

endmodule
`default_nettype wire

// File: rtl/rr_arb16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb16 : 16-way round-robin arbiter, grant held until release.     |
// | Optional forced release after HOLD_MAX cycles with ARB_TIMEOUT_EN.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arb16
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arb16_if.slave    bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arb16: HOLD_MAX must be in 1..255");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               tmo_q, tmo_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               rel_norm;
  logic               tmo_hit;
  logic [NREQ-1:0]    dec_oh;

  // Scan starts just past the last winner and wraps through 4-bit overflow.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && bus.req[ptr_q + IDX_W'(k + 1)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + IDX_W'(k + 1);
      end
    end
  end

  assign rel_norm = bus.done || !bus.req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign tmo_hit = (cnt_q == 8'(HOLD_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (win_found) cnt_d = 8'd1;
    end else if (!rel_norm && !tmo_hit) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_idx_d = win_idx;
          ptr_d     = win_idx;
          gnt_vld_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // A normal release takes precedence, so tmo only flags a true forced drop.
        if (rel_norm) begin
          gnt_vld_d = 1'b0;
          state_d   = IDLE;
        end else if (tmo_hit) begin
          gnt_vld_d = 1'b0;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      tmo_q     <= tmo_d;
    end
  end

  dec4to16 u_dec (
    .idx (gnt_idx_q),
    .oh  (dec_oh)
  );

  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_oh  = gnt_vld_q ? dec_oh : '0;
  assign bus.tmo     = tmo_q;

endmodule
`default_nettype wire
